// File: rtl/sr_latch_pkg.sv
// Shared types and helpers for the SR latch bank sequencer.
package sr_latch_pkg;

   typedef enum logic [1:0] {IDLE, PULSE, CHECK, GAP} state_t;

   localparam logic OP_SET = 1'b1;
   localparam logic OP_CLR = 1'b0;

   // Wide enough for PULSE_CYC and GAP_CYC up to 15.
   localparam int CNT_W = 4;

   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sr_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module sr_rr_arbiter
   import sr_latch_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int AW      = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [AW-1:0]      ptr,
   input  logic               enable,
   output logic [NUM_REQ-1:0] gnt,
   output logic [AW-1:0]      gnt_idx
);

   always_comb begin
      logic found;
      int   k;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      k       = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         k = (int'(ptr) + off) % NUM_REQ;
         if (enable && !found && req[k]) begin
            gnt[k]  = 1'b1;
            gnt_idx = AW'(k);
            found   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sr_latch_sequencer.sv
// Arbitrates set/clear commands onto a shared bank of active-low SR latches,
// pulses one latch input at a time and verifies the readback.
module sr_latch_sequencer
   import sr_latch_pkg::*;
#(
   parameter  int NUM_REQ   = 4,
   parameter  int NUM_LATCH = 8,
   parameter  int PULSE_CYC = 2,
   parameter  int GAP_CYC   = 1,
   localparam int IDXW      = idx_width(NUM_LATCH),
   localparam int AW        = idx_width(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ-1:0]      req_op,
   input  logic [NUM_REQ*IDXW-1:0] req_idx,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic [NUM_LATCH-1:0]    set_n,
   output logic [NUM_LATCH-1:0]    reset_n,
   input  logic [NUM_LATCH-1:0]    latch_q,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [IDXW-1:0]         err_idx
);

   localparam int PADW = 1 << IDXW;

   state_t               state_q, state_d;
   logic [AW-1:0]        ptr_q, ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 op_q, op_d;
   logic [IDXW-1:0]      idx_q, idx_d;
   logic [NUM_LATCH-1:0] set_n_q, set_n_d;
   logic [NUM_LATCH-1:0] reset_n_q, reset_n_d;
   logic [IDXW-1:0]      err_idx_q, err_idx_d;

   logic [NUM_REQ-1:0]   gnt;
   logic [AW-1:0]        gnt_idx;
   logic                 sel_op;
   logic [IDXW-1:0]      sel_idx;
   logic [NUM_LATCH-1:0] sel_hit;
   logic [PADW-1:0]      q_pad;
   logic                 cur_ok;

   sr_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req     (req_valid),
      .ptr     (ptr_q),
      .enable  (state_q == IDLE),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign sel_op  = req_op[gnt_idx];
   assign sel_idx = req_idx[int'(gnt_idx)*IDXW +: IDXW];

   // An out-of-range index decodes to no hit, so nothing is pulsed.
   generate
      for (genvar gi = 0; gi < NUM_LATCH; gi++) begin : g_dec
         assign sel_hit[gi] = (sel_idx == IDXW'(gi));
      end
   endgenerate

   always_comb begin
      q_pad                = '0;
      q_pad[NUM_LATCH-1:0] = latch_q;
   end

   assign cur_ok = ({1'b0, idx_q} < (IDXW+1)'(NUM_LATCH));

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      idx_d     = idx_q;
      set_n_d   = '1;
      reset_n_d = '1;
      err_idx_d = err_idx_q;
      done      = 1'b0;
      err       = 1'b0;
      case (state_q)
         IDLE: begin
            if (|gnt) begin
               op_d    = sel_op;
               idx_d   = sel_idx;
               ptr_d   = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
               cnt_d   = '0;
               state_d = PULSE;
               if (sel_op == OP_SET) set_n_d = ~sel_hit;
               else if (sel_op == OP_CLR) reset_n_d = ~sel_hit;
            end
         end
         PULSE: begin
            if (cnt_q == CNT_W'(PULSE_CYC - 1)) begin
               state_d   = CHECK;
               cnt_d     = '0;
               err_idx_d = idx_q;
            end else begin
               cnt_d     = cnt_q + 1'b1;
               set_n_d   = set_n_q;
               reset_n_d = reset_n_q;
            end
         end
         CHECK: begin
            done    = 1'b1;
            err     = !cur_ok || (q_pad[idx_q] != op_q);
            cnt_d   = '0;
            state_d = (GAP_CYC > 0) ? GAP : IDLE;
         end
         GAP: begin
            if (cnt_q == CNT_W'(GAP_CYC - 1)) state_d = IDLE;
            else cnt_d = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         cnt_q     <= '0;
         op_q      <= 1'b0;
         idx_q     <= '0;
         set_n_q   <= '1;
         reset_n_q <= '1;
         err_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         idx_q     <= idx_d;
         set_n_q   <= set_n_d;
         reset_n_q <= reset_n_d;
         err_idx_q <= err_idx_d;
      end
   end

   assign req_ready = gnt;
   assign set_n     = set_n_q;
   assign reset_n   = reset_n_q;
   assign busy      = (state_q != IDLE);
   assign err_idx   = err_idx_q;

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Randomised and directed checks of sr_latch_sequencer against a timeline model
// of grants, pulses and completions, with a behavioural latch bank.
module tb_sr_latch_sequencer;

   localparam int NR = 4;
   localparam int NL = 8;
   localparam int IW = 3;
   localparam int P  = 2;
   localparam int G  = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NR-1:0]    req_valid = '0, req_op = '0, req_ready;
   logic [NR*IW-1:0] req_idx = '0;
   logic [NL-1:0]    set_n, reset_n, latch_q;
   logic             busy, done, err;
   logic [IW-1:0]    err_idx;

   logic [NL-1:0] bank = '0;
   logic [NL-1:0] stuck0 = '0;
   assign latch_q = bank & ~stuck0;

   always @(posedge clk) begin
      for (int i = 0; i < NL; i++) begin
         if (!set_n[i]) bank[i] <= 1'b1;
         else if (!reset_n[i]) bank[i] <= 1'b0;
      end
   end

   sr_latch_sequencer #(.NUM_REQ(NR), .NUM_LATCH(NL), .PULSE_CYC(P), .GAP_CYC(G)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
      .req_ready(req_ready), .set_n(set_n), .reset_n(reset_n), .latch_q(latch_q),
      .busy(busy), .done(done), .err(err), .err_idx(err_idx)
   );

   // Second instance with a non-power-of-two bank for the out-of-range case.
   logic [NR-1:0]    req_valid6 = '0, req_op6 = '0, req_ready6;
   logic [NR*IW-1:0] req_idx6 = '0;
   logic [5:0]       set_n6, reset_n6;
   logic [5:0]       latch_q6 = '0;
   logic             busy6, done6, err6;
   logic [IW-1:0]    err_idx6;

   sr_latch_sequencer #(.NUM_REQ(NR), .NUM_LATCH(6), .PULSE_CYC(P), .GAP_CYC(G)) dut6 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid6), .req_op(req_op6), .req_idx(req_idx6),
      .req_ready(req_ready6), .set_n(set_n6), .reset_n(reset_n6), .latch_q(latch_q6),
      .busy(busy6), .done(done6), .err(err6), .err_idx(err_idx6)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Timeline model: a grant at cycle g owns cycles g+1..g+P (drive), g+P+1 (done)
   // and the bus is free again from g+P+G+2.
   int cyc = 0, mptr = 0, free_at = 0, g_cyc = 0, m_op = 0, m_idx = 0, m_req = 0;
   int last_idx = 0, last_g = -1;
   bit act = 0;
   int glog_req[$];
   int glog_cyc[$];

   task automatic model_reset();
      act = 0; free_at = 0; mptr = 0; last_idx = 0;
   endtask

   task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] op, input logic [NR*IW-1:0] idx);
      int g, k;
      logic [NR-1:0] er;
      logic [NL-1:0] es, erst;
      logic ed, ee, eb;
      @(negedge clk);
      req_valid = v; req_op = op; req_idx = idx;
      #1;
      g = -1;
      if (cyc >= free_at)
         for (int off = 0; off < NR; off++) begin
            k = (mptr + off) % NR;
            if (v[k] && g < 0) g = k;
         end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      es = '1; erst = '1; ed = 0; ee = 0; eb = 0;
      if (act) begin
         if (cyc >= g_cyc + 1 && cyc <= g_cyc + P && m_idx < NL) begin
            if (m_op == 1) es[m_idx] = 1'b0;
            else erst[m_idx] = 1'b0;
         end
         if (cyc == g_cyc + P + 1) begin
            ed = 1;
            ee = (m_idx >= NL) || (m_op == 1 && stuck0[m_idx]) || (m_op == 0 && 1'b0);
            last_idx = m_idx;
            $display("TXN cyc=%0d req=%0d op=%0d idx=%0d err=%0b", cyc, m_req, m_op, m_idx, err);
         end
         eb = (cyc > g_cyc) && (cyc < free_at);
      end
      chk("ready", req_ready, er);
      chk("set_n", set_n, es);
      chk("reset_n", reset_n, erst);
      chk("busy", busy, eb);
      chk("done", done, ed);
      chk("err", err, ee);
      chk("err_idx", err_idx, last_idx);
      chk("safety", (|(~set_n & ~reset_n)) || ($countones(~set_n) + $countones(~reset_n) > 1), 0);
      last_g = -1;
      for (int i = 0; i < NR; i++) if (req_ready[i]) last_g = i;
      if (last_g >= 0) begin
         glog_req.push_back(last_g);
         glog_cyc.push_back(cyc);
      end
      if (g >= 0) begin
         act = 1; m_req = g; m_op = int'(op[g]); m_idx = int'(idx[g*IW +: IW]);
         g_cyc = cyc; free_at = cyc + P + G + 2; mptr = (g + 1) % NR;
      end
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      req_valid = '0;
      rst_n = 1'b0;
      #1;
      chk("rst_set_n", set_n, {NL{1'b1}});
      chk("rst_reset_n", reset_n, {NL{1'b1}});
      chk("rst_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_err_idx", err_idx, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [NR-1:0] pend;
      logic [31:0] r;

      do_reset();

      // Single set on latch 3.
      step(4'b0001, 4'b0001, {9'd0, 3'd3});
      chk("single_grant_drive", set_n, 8'hFF);
      step('0, '0, '0);
      chk("single_pulse1", set_n, 8'hF7);
      step('0, '0, '0);
      chk("single_pulse2", set_n, 8'hF7);
      step('0, '0, '0);
      chk("single_done", done, 1);
      chk("single_err", err, 0);
      chk("single_err_idx", err_idx, 3);
      chk("single_q3", latch_q[3], 1);
      chk("single_idle_drive", set_n, 8'hFF);
      for (int i = 0; i < 3; i++) step('0, '0, '0);

      // Contention: all four requesters hold valid until granted.
      do_reset();
      glog_req.delete(); glog_cyc.delete();
      pend = 4'hF;
      for (int i = 0; i < 40; i++) begin
         step(pend, 4'b0101, {3'd6, 3'd4, 3'd2, 3'd1});
         if (last_g >= 0) pend[last_g] = 1'b0;
      end
      chk("cont_count", glog_req.size(), 4);
      for (int i = 0; i < glog_req.size(); i++) begin
         chk("cont_order", glog_req[i], i);
         if (i > 0) chk("cont_spacing", glog_cyc[i] - glog_cyc[i-1], P + G + 2);
      end
      glog_req.delete(); glog_cyc.delete();
      pend = 4'b1010;
      for (int i = 0; i < 20; i++) begin
         step(pend, 4'b1111, {3'd7, 3'd0, 3'd5, 3'd0});
         if (last_g >= 0) pend[last_g] = 1'b0;
      end
      chk("round2_count", glog_req.size(), 2);
      if (glog_req.size() == 2) begin
         chk("round2_first", glog_req[0], 1);
         chk("round2_second", glog_req[1], 3);
      end

      // Readback fault: latch 5 stuck at 0.
      stuck0 = 8'h20;
      step(4'b0100, 4'b0100, {3'd0, 3'd5, 3'd0, 3'd0});
      step('0, '0, '0);
      step('0, '0, '0);
      step('0, '0, '0);
      chk("fault_done", done, 1);
      chk("fault_err", err, 1);
      chk("fault_err_idx", err_idx, 5);
      for (int i = 0; i < 3; i++) step('0, '0, '0);
      stuck0 = '0;

      // Reset in the second pulse cycle.
      do_reset();
      step(4'b0001, 4'b0001, {9'd0, 3'd2});
      step('0, '0, '0);
      @(negedge clk);
      #1;
      chk("mid_low", set_n, 8'hFB);
      rst_n = 1'b0;
      #1;
      chk("mid_set_n", set_n, 8'hFF);
      chk("mid_reset_n", reset_n, 8'hFF);
      chk("mid_busy", busy, 0);
      chk("mid_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) step('0, '0, '0);
      step(4'b0011, 4'b0000, {3'd0, 3'd0, 3'd6, 3'd1});
      chk("mid_ptr_zero", req_ready, 4'b0001);
      for (int i = 0; i < 5; i++) step('0, '0, '0);

      // Random traffic with the safety invariant checked every cycle.
      for (int i = 0; i < 10000; i++) begin
         logic [NR-1:0] rv, ro;
         logic [NR*IW-1:0] ri;
         r = $urandom; rv = r[NR-1:0];
         r = $urandom; ro = r[NR-1:0];
         r = $urandom; ri = r[NR*IW-1:0];
         step(rv, ro, ri);
      end

      // Out-of-range index on the 6-latch instance.
      do_reset();
      @(negedge clk);
      req_valid6 = 4'b0001; req_op6 = 4'b0001; req_idx6 = {9'd0, 3'd7};
      #1;
      chk("oor_ready", req_ready6, 4'b0001);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (i == 1) req_valid6 = '0;
         #1;
         chk("oor_set_n", set_n6, 6'h3F);
         chk("oor_reset_n", reset_n6, 6'h3F);
         chk("oor_done", done6, (i == P + 1) ? 1 : 0);
         chk("oor_err", err6, (i == P + 1) ? 1 : 0);
         if (i == P + 1) chk("oor_err_idx", err_idx6, 7);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
